// File: rtl/s27_bist_ctrl_if.sv
// Handshake and data bundle between the s27 BIST controller and its user/core.
// START/PO flow into the controller; stimulus, status and signature flow out.
interface s27_bist_ctrl_if #(
  parameter int SIG_W = 8
);
  logic             START;
  logic             PO;
  logic [3:0]       PI;
  logic             BUSY;
  logic             DONE;
  logic [SIG_W-1:0] SIG;
  logic             PASS;

  modport master (
    output START, PO,
    input  PI, BUSY, DONE, SIG, PASS
  );

  modport slave (
    input  START, PO,
    output PI, BUSY, DONE, SIG, PASS
  );
endinterface

// File: rtl/s27_bist_ctrl.sv
// BIST wrapper for the s27 core: LFSR stimulus on PI, serial signature
// compaction of PO, and a pass flag against a golden signature.
//
// state   | meaning
// --------+---------------------------------------------------------
// S_IDLE  | waiting for START after reset, PI held at zero
// S_FLUSH | PI held at zero for FLUSH_CYC cycles to settle the core
// S_RUN   | PI driven from the LFSR, PO folded into the signature
// S_DONE  | signature frozen, DONE/PASS reported, waiting for START
module s27_bist_ctrl #(
  parameter logic [3:0] SEED      = 4'b0001,
  parameter int         N_PAT     = 15,
  parameter int         FLUSH_CYC = 4,
  parameter int         SIG_W     = 8,
  parameter logic [SIG_W-1:0] TAPS   = 8'hB8,
  parameter logic [SIG_W-1:0] GOLDEN = 8'h1C
) (
  input logic             CK,
  input logic             RST,
  s27_bist_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FLUSH = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [7:0] FLUSH_LAST = 8'(FLUSH_CYC - 1);
  localparam logic [7:0] RUN_LAST   = 8'(N_PAT - 1);
  localparam state_t     FIRST_ST   = (FLUSH_CYC == 0) ? S_RUN : S_FLUSH;

  state_t           r_state;
  logic [3:0]       r_lfsr;
  logic [SIG_W-1:0] r_sig;
  logic [7:0]       r_cnt;
  logic             r_busy;
  logic             r_done;

  logic             w_fb;
  logic [SIG_W-1:0] w_sig_next;
  logic [3:0]       w_lfsr_next;

  assign w_fb        = (^(r_sig & TAPS)) ^ bus.PO;
  assign w_sig_next  = {r_sig[SIG_W-2:0], w_fb};
  assign w_lfsr_next = {r_lfsr[2:0], r_lfsr[3] ^ r_lfsr[2]};

  always_ff @(posedge CK) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_lfsr  <= SEED;
      r_sig   <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (bus.START) begin
            r_state <= FIRST_ST;
            r_lfsr  <= SEED;
            r_sig   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
          end
        end
        S_FLUSH: begin
          if (r_cnt == FLUSH_LAST) begin
            r_state <= S_RUN;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_RUN: begin
          r_sig  <= w_sig_next;
          r_lfsr <= w_lfsr_next;
          r_cnt  <= r_cnt + 8'd1;
          if (r_cnt == RUN_LAST) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
      endcase
    end
  end

  // Stimulus is a decode of registered state so PO lines up with the same edge.
  assign bus.PI   = (r_state == S_RUN) ? r_lfsr : 4'b0000;
  assign bus.BUSY = r_busy;
  assign bus.DONE = r_done;
  assign bus.SIG  = r_sig;
  assign bus.PASS = r_done && (r_sig == GOLDEN);

endmodule

// File: tb/tb_s27_bist_ctrl.sv
// Bench for s27_bist_ctrl: per-cycle scoreboard of PI/BUSY/DONE/SIG/PASS,
// with PO from constants or a behavioural s27 core.
module tb_s27_bist_ctrl;

  logic CK;
  logic RST;

  s27_bist_ctrl_if #(.SIG_W(8)) b0 ();
  s27_bist_ctrl_if #(.SIG_W(8)) b1 ();

  s27_bist_ctrl u_dut (
    .CK  (CK),
    .RST (RST),
    .bus (b0)
  );

  s27_bist_ctrl #(.FLUSH_CYC(0), .N_PAT(1)) u_short (
    .CK  (CK),
    .RST (RST),
    .bus (b1)
  );

  initial begin
    CK = 1'b0;
    forever #5 CK = ~CK;
  end

  typedef struct {
    logic [3:0] pi;
    logic       busy;
    logic       done;
    logic [7:0] sig;
    logic       pass;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [3:0] lfsr_tab [15] = '{4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA,
                                4'h5, 4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8};

  // s27 netlist; returns {G17, G13, G11, G10}, state is {G7, G6, G5}
  function automatic logic [3:0] s27_eval(input logic [3:0] pi, input logic [2:0] st);
    logic g8, g9, g10, g11, g12, g13, g14, g15, g16;
    g14 = ~pi[0];
    g8  = g14 & st[1];
    g12 = ~(pi[1] | st[2]);
    g15 = g12 | g8;
    g16 = pi[3] | g8;
    g9  = ~(g16 & g15);
    g11 = ~(st[0] | g9);
    g10 = ~(g14 | g11);
    g13 = ~(pi[2] | g12);
    return {~g11, g13, g11, g10};
  endfunction

  logic [1:0] po_mode;
  logic [2:0] core_st;
  logic [3:0] core_r;

  assign core_r = s27_eval(b0.PI, core_st);
  assign b0.PO  = (po_mode == 2'd2) ? core_r[3] : po_mode[0];
  assign b1.PO  = 1'b1;

  always @(posedge CK) begin
    if (RST) core_st <= 3'b000;
    else     core_st <= core_r[2:0];
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Queue one default run (4 flush + 15 run cycles) plus n_done DONE cycles.
  task automatic plan_run(input logic [1:0] mode, input int n_done);
    logic [7:0] s;
    logic [2:0] st;
    logic [3:0] p;
    logic [3:0] r;
    logic       po;
    exp_t       e;
    s  = 8'h00;
    st = core_st;
    r  = s27_eval(4'b0000, st);
    st = r[2:0];
    for (int i = 0; i < 19; i++) begin
      p = (i < 4) ? 4'b0000 : lfsr_tab[i-4];
      r = s27_eval(p, st);
      e = '{pi: p, busy: 1'b1, done: 1'b0, sig: s, pass: 1'b0};
      q.push_back(e);
      if (i >= 4) begin
        po = (mode == 2'd2) ? r[3] : mode[0];
        s  = {s[6:0], (^(s & 8'hB8)) ^ po};
      end
      st = r[2:0];
    end
    for (int i = 0; i < n_done; i++) begin
      e = '{pi: 4'b0000, busy: 1'b0, done: 1'b1, sig: s, pass: (s == 8'h1C)};
      q.push_back(e);
    end
  endtask

  task automatic start_and_check(input string tag, input logic hold, input logic jitter);
    exp_t e;
    int   cyc;
    cyc = 0;
    b0.START = 1'b1;
    @(negedge CK);
    b0.START = hold;
    while (q.size() > 0) begin
      e = q.pop_front();
      cyc++;
      chk($sformatf("%s c%0d PI", tag, cyc),   32'(b0.PI),   32'(e.pi));
      chk($sformatf("%s c%0d BUSY", tag, cyc), 32'(b0.BUSY), 32'(e.busy));
      chk($sformatf("%s c%0d DONE", tag, cyc), 32'(b0.DONE), 32'(e.done));
      chk($sformatf("%s c%0d SIG", tag, cyc),  32'(b0.SIG),  32'(e.sig));
      chk($sformatf("%s c%0d PASS", tag, cyc), 32'(b0.PASS), 32'(e.pass));
      if (e.busy && jitter) b0.START = 1'($urandom_range(0, 1));
      else                  b0.START = hold;
      @(negedge CK);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " PI"},   32'(b0.PI),   32'h0);
    chk({tag, " BUSY"}, 32'(b0.BUSY), 32'h0);
    chk({tag, " DONE"}, 32'(b0.DONE), 32'h0);
    chk({tag, " SIG"},  32'(b0.SIG),  32'h0);
    chk({tag, " PASS"}, 32'(b0.PASS), 32'h0);
  endtask

  initial begin
    RST      = 1'b1;
    b0.START = 1'b1;
    b1.START = 1'b1;
    po_mode  = 2'd0;
    repeat (3) @(negedge CK);
    b0.START = 1'b0;
    b1.START = 1'b0;
    RST      = 1'b0;
    chk_idle("rst");
    chk("rst b1 SIG", 32'(b1.SIG), 32'h0);
    chk("rst b1 DONE", 32'(b1.DONE), 32'h0);
    @(negedge CK);
    chk_idle("idle");

    // PO tied low: zero signature, DONE held while START stays low
    po_mode = 2'd0;
    plan_run(2'd0, 3);
    start_and_check("po0", 1'b0, 1'b0);

    // PO tied high: golden signature, START pulses during BUSY ignored
    po_mode = 2'd1;
    plan_run(2'd1, 2);
    start_and_check("po1", 1'b0, 1'b1);

    // Real s27 core behind PO, two runs back from DONE
    po_mode = 2'd2;
    plan_run(2'd2, 2);
    start_and_check("core1", 1'b0, 1'b0);
    plan_run(2'd2, 2);
    start_and_check("core2", 1'b0, 1'b0);

    // Reset in the 7th RUN cycle, then a clean PO-high run
    po_mode = 2'd1;
    plan_run(2'd1, 1);
    while (q.size() > 10) void'(q.pop_back());
    start_and_check("rstmid", 1'b0, 1'b0);
    chk("rstmid run7 PI", 32'(b0.PI), 32'(lfsr_tab[6]));
    RST = 1'b1;
    @(negedge CK);
    RST = 1'b0;
    chk_idle("rstmid after");
    @(negedge CK);
    plan_run(2'd1, 2);
    start_and_check("after_rst", 1'b0, 1'b0);

    // START held high: back-to-back runs with a single DONE cycle
    plan_run(2'd1, 1);
    plan_run(2'd1, 1);
    start_and_check("hold", 1'b1, 1'b0);
    chk("hold rerun BUSY", 32'(b0.BUSY), 32'h1);
    chk("hold rerun PI", 32'(b0.PI), 32'h0);
    b0.START = 1'b0;
    RST = 1'b1;
    @(negedge CK);
    RST = 1'b0;
    chk_idle("hold rst");

    // FLUSH_CYC=0, N_PAT=1 instance
    b1.START = 1'b1;
    @(negedge CK);
    b1.START = 1'b0;
    chk("short PI", 32'(b1.PI), 32'h1);
    chk("short BUSY", 32'(b1.BUSY), 32'h1);
    chk("short DONE0", 32'(b1.DONE), 32'h0);
    @(negedge CK);
    chk("short DONE", 32'(b1.DONE), 32'h1);
    chk("short SIG", 32'(b1.SIG), 32'h01);
    chk("short PASS", 32'(b1.PASS), 32'h0);
    chk("short PI0", 32'(b1.PI), 32'h0);
    chk("short BUSY0", 32'(b1.BUSY), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
